seg7_mux_driver: RTL and testbench

Time-multiplexed driver for NDIG common-anode (or common-cathode) 7-segment digits sharing one segment bus. It latches a packed 4-bit-per-digit value on a load strobe and scans the digits round-robin with a programmable dwell. Each digit change is preceded by a one-cycle blanking slot to suppress ghosting. It decodes 0-9 and, per mode, either hex A-F or the letter "H" for out-of-range codes. It sits between the datapath and the board display pins.

---
 rtl/seg7_mux_driver_if.sv | 23 ++
 rtl/seg7_mux_driver.sv | 120 ++++++++++++
 tb/tb_seg7_mux_driver.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_mux_driver_if.sv
// Digit-value and display-pin bundle between the datapath and the 7-segment scan driver.
// The master side supplies digit codes and requests; the slave side drives the pins.
interface seg7_mux_driver_if #(
   parameter int unsigned NDIG = 4
);
   logic [4*NDIG-1:0] val;
   logic [NDIG-1:0]   dp_in;
   logic [NDIG-1:0]   blank_in;
   logic              load;
   logic [6:0]        seg;
   logic              dp;
   logic [NDIG-1:0]   an;

   modport master (
      output val, dp_in, blank_in, load,
      input  seg, dp, an
   );

   modport slave (
      input  val, dp_in, blank_in, load,
      output seg, dp, an
   );
endinterface

// File: rtl/seg7_mux_driver.sv
// Round-robin 7-segment scan driver.
// Each digit slot is one blank cycle followed by DIV-1 drive cycles; outputs are registered with polarity applied last.
module seg7_mux_driver #(
   parameter int unsigned NDIG       = 4,
   parameter int unsigned DIV        = 50000,
   parameter int unsigned ACTIVE_LOW = 1,
   parameter int unsigned HEX_MODE   = 0
) (
   input logic              clk,
   input logic              reset,
   seg7_mux_driver_if.slave bus
);
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned IW  = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic        POL = (ACTIVE_LOW != 0);

   logic [CW-1:0]     r_cnt;
   logic [IW-1:0]     r_idx;
   logic [4*NDIG-1:0] r_sh_val;
   logic [NDIG-1:0]   r_sh_dp;
   logic [NDIG-1:0]   r_sh_blank;
   logic [6:0]        r_seg;
   logic              r_dp;
   logic [NDIG-1:0]   r_an;

   logic              w_wrap;
   logic              w_drive;
   logic [3:0]        w_code;
   logic              w_dp;
   logic              w_blk;
   logic [NDIG-1:0]   w_an;
   logic [6:0]        w_seg;

   // Active-high abcdefg pattern for one digit code
   function automatic logic [6:0] decode(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1110011;
         4'd10:   s = (HEX_MODE != 0) ? 7'b1110111 : 7'b0110111;
         4'd11:   s = (HEX_MODE != 0) ? 7'b0011111 : 7'b0110111;
         4'd12:   s = (HEX_MODE != 0) ? 7'b1001110 : 7'b0110111;
         4'd13:   s = (HEX_MODE != 0) ? 7'b0111101 : 7'b0110111;
         4'd14:   s = (HEX_MODE != 0) ? 7'b1001111 : 7'b0110111;
         default: s = (HEX_MODE != 0) ? 7'b1000111 : 7'b0110111;
      endcase
      return s;
   endfunction

   assign w_wrap  = (r_cnt == CW'(DIV - 1));
   assign w_drive = (r_cnt != '0);

   // Prescaler and digit index
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (w_wrap) begin
         r_cnt <= '0;
         r_idx <= (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + IW'(1);
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Shadow copies of the digit request, taken on load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sh_val   <= '0;
         r_sh_dp    <= '0;
         r_sh_blank <= '0;
      end else if (bus.load) begin
         r_sh_val   <= bus.val;
         r_sh_dp    <= bus.dp_in;
         r_sh_blank <= bus.blank_in;
      end
   end

   // Select the current digit's shadow fields and its one-hot enable
   always_comb begin
      w_code = '0;
      w_dp   = 1'b0;
      w_blk  = 1'b0;
      w_an   = '0;
      for (int i = 0; i < int'(NDIG); i++) begin
         if (r_idx == IW'(i)) begin
            w_code  = r_sh_val[4*i +: 4];
            w_dp    = r_sh_dp[i];
            w_blk   = r_sh_blank[i];
            w_an[i] = 1'b1;
         end
      end
      w_seg = decode(w_code);
   end

   // Output register; logic is active-high until the final polarity XOR
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seg <= {7{POL}};
         r_dp  <= POL;
         r_an  <= {NDIG{POL}};
      end else begin
         r_seg <= ((w_drive && !w_blk) ? w_seg : 7'h00) ^ {7{POL}};
         r_dp  <= (w_drive && !w_blk && w_dp) ^ POL;
         r_an  <= (w_drive ? w_an : {NDIG{1'b0}}) ^ {NDIG{POL}};
      end
   end

   assign bus.seg = r_seg;
   assign bus.dp  = r_dp;
   assign bus.an  = r_an;
endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver: three instances (active-low decimal, active-low hex,
// active-high) share one stimulus stream and are checked against hand-computed patterns.
module tb_seg7_mux_driver;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   seg7_mux_driver_if #(.NDIG(4)) if_a ();
   seg7_mux_driver_if #(.NDIG(4)) if_b ();
   seg7_mux_driver_if #(.NDIG(4)) if_c ();

   assign if_b.val      = if_a.val;
   assign if_b.dp_in    = if_a.dp_in;
   assign if_b.blank_in = if_a.blank_in;
   assign if_b.load     = if_a.load;
   assign if_c.val      = if_a.val;
   assign if_c.dp_in    = if_a.dp_in;
   assign if_c.blank_in = if_a.blank_in;
   assign if_c.load     = if_a.load;

   seg7_mux_driver #(.NDIG(4), .DIV(4), .ACTIVE_LOW(1), .HEX_MODE(0)) dut_a (
      .clk(clk), .reset(reset), .bus(if_a.slave));
   seg7_mux_driver #(.NDIG(4), .DIV(4), .ACTIVE_LOW(1), .HEX_MODE(1)) dut_b (
      .clk(clk), .reset(reset), .bus(if_b.slave));
   seg7_mux_driver #(.NDIG(4), .DIV(4), .ACTIVE_LOW(0), .HEX_MODE(0)) dut_c (
      .clk(clk), .reset(reset), .bus(if_c.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold reset, present a request with load high, release; returns just after the first (blank) edge
   task automatic start(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      reset         = 1'b1;
      if_a.val      = v;
      if_a.dp_in    = d;
      if_a.blank_in = b;
      if_a.load     = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      if_a.load = 1'b0;
   endtask

   task automatic test_reset();
      start(16'h9876, 4'b0000, 4'b0000);
      repeat (5) tick();
      checks++;
      if (if_a.an !== 4'b1101) begin
         errors++;
         $display("FAIL reset_prescan_an: got %b expected %b", if_a.an, 4'b1101);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (if_a.seg !== 7'h7F || if_a.dp !== 1'b1 || if_a.an !== 4'b1111) begin
         errors++;
         $display("FAIL reset_async_a: got seg=%h dp=%b an=%b expected seg=7f dp=1 an=1111",
                  if_a.seg, if_a.dp, if_a.an);
      end
      checks++;
      if (if_c.seg !== 7'h00 || if_c.dp !== 1'b0 || if_c.an !== 4'b0000) begin
         errors++;
         $display("FAIL reset_async_c: got seg=%h dp=%b an=%b expected seg=00 dp=0 an=0000",
                  if_c.seg, if_c.dp, if_c.an);
      end
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if (if_a.an !== 4'b1111 || if_a.seg !== 7'h7F) begin
         errors++;
         $display("FAIL reset_first_blank: got seg=%h an=%b expected seg=7f an=1111", if_a.seg, if_a.an);
      end
      tick();
      checks++;
      if (if_a.an !== 4'b1110 || if_a.seg !== 7'b0000001) begin
         errors++;
         $display("FAIL reset_first_drive: got seg=%b an=%b expected seg=0000001 an=1110",
                  if_a.seg, if_a.an);
      end
   endtask

   task automatic test_scan();
      logic [6:0] exp_seg [5];
      logic [3:0] exp_an  [5];
      exp_seg = '{7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100, 7'b0100000};
      exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      start(16'h9876, 4'b0000, 4'b0000);
      for (int s = 0; s < 5; s++) begin
         if (s != 0) begin
            tick();
            checks++;
            if (if_a.an !== 4'b1111 || if_a.seg !== 7'h7F || if_a.dp !== 1'b1) begin
               errors++;
               $display("FAIL scan_blank slot%0d: got seg=%h dp=%b an=%b expected seg=7f dp=1 an=1111",
                        s, if_a.seg, if_a.dp, if_a.an);
            end
         end
         for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (if_a.an !== exp_an[s] || if_a.seg !== exp_seg[s]) begin
               errors++;
               $display("FAIL scan_drive slot%0d cyc%0d: got seg=%b an=%b expected seg=%b an=%b",
                        s, c, if_a.seg, if_a.an, exp_seg[s], exp_an[s]);
            end
         end
      end
   endtask

   task automatic test_out_of_range();
      logic [6:0] exp_a [4];
      logic [6:0] exp_b [4];
      exp_a = '{7'b0100100, 7'b0000001, 7'b1001000, 7'b1001000};
      exp_b = '{7'b0100100, 7'b0000001, 7'b0001000, 7'b0111000};
      start(16'hFA05, 4'b0000, 4'b0000);
      for (int s = 0; s < 4; s++) begin
         if (s != 0) tick();
         tick();
         checks++;
         if (if_a.seg !== exp_a[s]) begin
            errors++;
            $display("FAIL range_dec digit%0d: got %b expected %b", s, if_a.seg, exp_a[s]);
         end
         checks++;
         if (if_b.seg !== exp_b[s]) begin
            errors++;
            $display("FAIL range_hex digit%0d: got %b expected %b", s, if_b.seg, exp_b[s]);
         end
         tick();
         tick();
      end
   endtask

   task automatic test_blank_dp();
      logic [6:0] exp_seg [4];
      logic       exp_dp  [4];
      logic [3:0] exp_an  [4];
      exp_seg = '{7'b0100000, 7'b0001111, 7'b0000000, 7'b1111111};
      exp_dp  = '{1'b1, 1'b0, 1'b1, 1'b1};
      exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      start(16'h9876, 4'b0010, 4'b1000);
      for (int s = 0; s < 4; s++) begin
         if (s != 0) begin
            tick();
            checks++;
            if (if_a.dp !== 1'b1) begin
               errors++;
               $display("FAIL blankdp_blank_dp slot%0d: got %b expected 1", s, if_a.dp);
            end
         end
         for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (if_a.seg !== exp_seg[s] || if_a.dp !== exp_dp[s] || if_a.an !== exp_an[s]) begin
               errors++;
               $display("FAIL blankdp digit%0d cyc%0d: got seg=%b dp=%b an=%b expected seg=%b dp=%b an=%b",
                        s, c, if_a.seg, if_a.dp, if_a.an, exp_seg[s], exp_dp[s], exp_an[s]);
            end
         end
      end
   endtask

   task automatic test_load_timing();
      start(16'h0000, 4'b0000, 4'b0000);
      tick();
      checks++;
      if (if_a.seg !== 7'b0000001 || if_a.an !== 4'b1110) begin
         errors++;
         $display("FAIL load_before: got seg=%b an=%b expected seg=0000001 an=1110", if_a.seg, if_a.an);
      end
      if_a.val  = 16'h1111;
      if_a.load = 1'b1;
      tick();
      if_a.load = 1'b0;
      checks++;
      if (if_a.seg !== 7'b0000001 || if_a.an !== 4'b1110) begin
         errors++;
         $display("FAIL load_same_edge: got seg=%b an=%b expected seg=0000001 an=1110", if_a.seg, if_a.an);
      end
      tick();
      checks++;
      if (if_a.seg !== 7'b1001111 || if_a.an !== 4'b1110) begin
         errors++;
         $display("FAIL load_next_edge: got seg=%b an=%b expected seg=1001111 an=1110", if_a.seg, if_a.an);
      end
   endtask

   task automatic test_back_to_back();
      start(16'h0000, 4'b0000, 4'b0000);
      tick();
      tick();
      if_a.val  = 16'h2222;
      if_a.load = 1'b1;
      tick();
      checks++;
      if (if_a.seg !== 7'b0000001) begin
         errors++;
         $display("FAIL b2b_old_value: got %b expected 0000001", if_a.seg);
      end
      if_a.val = 16'h4444;
      tick();
      if_a.load = 1'b0;
      checks++;
      if (if_a.an !== 4'b1111 || if_a.seg !== 7'h7F) begin
         errors++;
         $display("FAIL b2b_blank: got seg=%h an=%b expected seg=7f an=1111", if_a.seg, if_a.an);
      end
      tick();
      checks++;
      if (if_a.seg !== 7'b1001100 || if_a.an !== 4'b1101) begin
         errors++;
         $display("FAIL b2b_last_wins: got seg=%b an=%b expected seg=1001100 an=1101", if_a.seg, if_a.an);
      end
   endtask

   task automatic test_polarity();
      start(16'h0008, 4'b0000, 4'b0000);
      checks++;
      if (if_c.seg !== 7'h00 || if_c.an !== 4'b0000 || if_c.dp !== 1'b0) begin
         errors++;
         $display("FAIL pol_blank: got seg=%h dp=%b an=%b expected seg=00 dp=0 an=0000",
                  if_c.seg, if_c.dp, if_c.an);
      end
      tick();
      checks++;
      if (if_c.seg !== 7'b1111111 || if_c.an !== 4'b0001 || if_c.dp !== 1'b0) begin
         errors++;
         $display("FAIL pol_drive: got seg=%b dp=%b an=%b expected seg=1111111 dp=0 an=0001",
                  if_c.seg, if_c.dp, if_c.an);
      end
      checks++;
      if (if_a.seg !== 7'b0000000 || if_a.an !== 4'b1110) begin
         errors++;
         $display("FAIL pol_drive_lowref: got seg=%b an=%b expected seg=0000000 an=1110", if_a.seg, if_a.an);
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      reset         = 1'b1;
      if_a.val      = '0;
      if_a.dp_in    = '0;
      if_a.blank_in = '0;
      if_a.load     = 1'b0;
      #1;
      checks++;
      if (if_a.seg !== 7'h7F || if_a.dp !== 1'b1 || if_a.an !== 4'b1111) begin
         errors++;
         $display("FAIL reset_initial: got seg=%h dp=%b an=%b expected seg=7f dp=1 an=1111",
                  if_a.seg, if_a.dp, if_a.an);
      end
      test_reset();
      test_scan();
      test_out_of_range();
      test_blank_dp();
      test_load_timing();
      test_back_to_back();
      test_polarity();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
